mem_access_controller: RTL
==========================

# mem_access_controller

Sequences every data-memory access of the multi-cycle MIPS core. It takes a load/store opcode and effective address from the execute stage, drives a word-addressed, waitrequest-stalled memory bus with correct byte enables and lane-steered write data, and returns the lane-selected, sign- or zero-extended load result. It holds `busy` so the core stalls until the access completes.

## Interface
No parameters (data and address fixed at 32 bits).
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request strobe, sampled only in IDLE
- `opcode`  in  6  instruction opcode (LB, LBU, LH, LHU, LW, SB, SH, SW)
- `eff_addr`  in  32  byte address (base + extended offset)
- `store_data`  in  32  rt value for stores
- `mem_waitrequest`  in  1  bus stall
- `mem_readdata`  in  32  bus read data
- `mem_address`  out  32  word-aligned address: `{addr[31:2],2'b00}`
- `mem_read` / `mem_write`  out  1  bus strobes
- `mem_byteenable`  out  4  active lanes
- `mem_writedata`  out  32  lane-steered store data
- `busy`  out  1  high from the cycle after an accepted `start` through the DONE state
- `done`  out  1  one-cycle completion pulse
- `load_data`  out  32  extended load result, valid while `done`=1 and held until next completion
- `misaligned`  out  1  one-cycle pulse on an address error

Reset is synchronous, active-high. All outputs reset to 0.

## Operation
- States: IDLE, ACCESS, DONE, held in a 2-bit encoding.
- IDLE: on `start`=1 with a memory opcode, latch opcode, address and store data. An aligned access moves to ACCESS. A misaligned access (halfword with addr[0]=1, word with addr[1:0]≠0) pulses `misaligned` for the next cycle and stays in IDLE with no bus cycle. A non-memory opcode is ignored.
- ACCESS: assert `mem_read` (loads) or `mem_write` (stores). Address, byteenable and writedata are constant while `mem_waitrequest`=1. On the cycle `mem_waitrequest`=0, the transfer completes: loads capture the extended data, then the FSM goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE. `start` is ignored in DONE and ACCESS.
- Lanes are little-endian: byte k is `[8k+7:8k]`, selected by addr[1:0].
  - Byte: byteenable `1 << addr[1:0]`.
  - Half: `0011` when addr[1]=0, `1100` when addr[1]=1.
  - Word: `1111`.
- Stores: SB replicates `store_data[7:0]` into all four lanes. SH replicates `store_data[15:0]` into both halves. SW passes data through.
- Loads: LB and LH sign-extend bit 7 / bit 15 of the selected lane. LBU and LHU zero-extend. LW passes the word through.
- `reset` in any state: IDLE on the next edge, bus strobes deasserted at that edge, the in-flight access is abandoned, `load_data` is cleared.

## Timing
- Zero wait states: `start` at edge N → ACCESS in cycle N+1 (strobe high) → DONE in cycle N+2 (`done`=1) → accepts `start` again in cycle N+3.
- Each cycle with `mem_waitrequest`=1 in ACCESS adds one cycle of latency.
- `misaligned` is high exactly in cycle N+1. `busy` stays 0 for a misaligned access.
- All outputs are registered or decoded from state and latched registers only. There is no combinational path from `mem_readdata` or `mem_waitrequest` to any output other than via the next edge.

## Structure
- Shared package holds:
  - the `OPCODE_LB/LH/LW/LBU/LHU/SB/SH/SW` constants (0x20, 0x21, 0x23, 0x24, 0x25, 0x28, 0x29, 0x2B);
  - the FSM state typedef;
  - a `mem_size_t` (BYTE, HALF, WORD) decode.
- One combinational sub-module, `load_extend`, takes the size, the signed flag, addr[1:0] and readdata, and produces the 32-bit result. The FSM, lane steering and byteenable logic stay in the top module.

## Test plan
- LW addr 0x1000, readdata 0x8765_4321, no wait → `mem_read` in cycle N+1, byteenable 1111, `done` at N+2, `load_data`=0x8765_4321.
- LB addr 0x1003, readdata 0x80FF_FFFF → byteenable 1000, `load_data`=0xFFFF_FF80. LBU on the same access → 0x0000_0080.
- SH addr 0x2002, store_data 0x1234_BEEF, 3 wait cycles → `mem_write` held 4 cycles, address 0x2000, byteenable 1100, writedata 0xBEEF_BEEF, `done` at N+5.
- LW addr 0x1002 → `misaligned` pulse at N+1, no strobes, `busy`=0. LH addr 0x1001 gives the same.
- `start` asserted during ACCESS and DONE → ignored, no second access. `reset` asserted mid-wait → strobes low and state IDLE after that edge, no `done` pulse.

Source files
------------

// File: rtl/mem_access_controller_pkg.sv
// Shared definitions for the data-memory access controller: opcodes, FSM
// state encoding, access-size decode and the bus request payload.
package mem_access_controller_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned BE_W   = 4;

  localparam logic [OP_W-1:0] OPCODE_LB  = 6'h20;
  localparam logic [OP_W-1:0] OPCODE_LH  = 6'h21;
  localparam logic [OP_W-1:0] OPCODE_LW  = 6'h23;
  localparam logic [OP_W-1:0] OPCODE_LBU = 6'h24;
  localparam logic [OP_W-1:0] OPCODE_LHU = 6'h25;
  localparam logic [OP_W-1:0] OPCODE_SB  = 6'h28;
  localparam logic [OP_W-1:0] OPCODE_SH  = 6'h29;
  localparam logic [OP_W-1:0] OPCODE_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
  } bus_req_t;

  // True for any of the eight load/store opcodes
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    case (op)
      OPCODE_LB, OPCODE_LH, OPCODE_LW, OPCODE_LBU, OPCODE_LHU,
      OPCODE_SB, OPCODE_SH, OPCODE_SW: is_mem_op = 1'b1;
      default:                         is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    case (op)
      OPCODE_SB, OPCODE_SH, OPCODE_SW: is_store = 1'b1;
      default:                         is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_load(input logic [OP_W-1:0] op);
    case (op)
      OPCODE_LB, OPCODE_LH: is_signed_load = 1'b1;
      default:              is_signed_load = 1'b0;
    endcase
  endfunction

  // Non-memory opcodes decode as WORD; they are filtered out before use
  function automatic mem_size_t op_size(input logic [OP_W-1:0] op);
    case (op)
      OPCODE_LB, OPCODE_LBU, OPCODE_SB: op_size = SIZE_BYTE;
      OPCODE_LH, OPCODE_LHU, OPCODE_SH: op_size = SIZE_HALF;
      default:                          op_size = SIZE_WORD;
    endcase
  endfunction

  function automatic logic addr_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    case (size)
      SIZE_HALF: addr_misaligned = addr_lo[0];
      SIZE_WORD: addr_misaligned = |addr_lo;
      default:   addr_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_controller_load_extend.sv
// load_extend: selects the addressed byte/halfword lane of a bus read word and
// sign- or zero-extends it to 32 bits. Purely combinational.
//   size      access size (mem_size_t encoding)
//   is_signed 1 = sign-extend (LB/LH), 0 = zero-extend
//   addr_lo   byte offset within the word
//   readdata  raw bus read word
//   result_c  extended load value
module load_extend
  import mem_access_controller_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] readdata,
  output logic [DATA_W-1:0] result_c
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Little-endian lane select, then extension by size
  always_comb begin
    lane_byte = readdata[{addr_lo, 3'b000} +: 8];
    lane_half = addr_lo[1] ? readdata[31:16] : readdata[15:0];
    case (size)
      SIZE_BYTE: result_c = {{24{is_signed & lane_byte[7]}}, lane_byte};
      SIZE_HALF: result_c = {{16{is_signed & lane_half[15]}}, lane_half};
      default:   result_c = readdata;
    endcase
  end

endmodule

// File: rtl/mem_access_controller.sv
// mem_access_controller: sequences one data-memory access per start strobe on
// a word-addressed, waitrequest-stalled bus and returns the extended load value.
//   clk, reset              clock, synchronous active-high reset
//   start, opcode, eff_addr request from execute (sampled in IDLE only)
//   store_data              rt value for stores
//   mem_*                   memory bus (address/read/write/byteenable/writedata
//                           out; waitrequest/readdata in)
//   busy                    core stall, accepted access through DONE
//   done                    one-cycle completion pulse
//   load_data               extended load result, held until next load completes
//   misaligned              one-cycle address-error pulse
module mem_access_controller
  import mem_access_controller_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   opcode,
  input  logic [ADDR_W-1:0] eff_addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_waitrequest,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] load_data,
  output logic              misaligned
);

  state_t            state, state_next;
  logic [OP_W-1:0]   op_q;
  logic [1:0]        addr_lo_q;
  logic              accept_c;
  logic              misalign_c;
  logic              complete_c;
  mem_size_t         req_size_c;
  bus_req_t          req_c;
  mem_size_t         held_size_c;
  logic              held_signed_c;
  logic              held_store_c;
  logic [DATA_W-1:0] ext_data_c;

  // Bus request built from the incoming opcode/address; only used on accept
  always_comb begin
    req_size_c         = op_size(opcode);
    req_c.address      = {eff_addr[ADDR_W-1:2], 2'b00};
    req_c.byteenable   = 4'b1111;
    req_c.writedata    = store_data;
    case (req_size_c)
      SIZE_BYTE: begin
        req_c.byteenable = 4'b0001 << eff_addr[1:0];
        req_c.writedata  = {4{store_data[7:0]}};
      end
      SIZE_HALF: begin
        req_c.byteenable = eff_addr[1] ? 4'b1100 : 4'b0011;
        req_c.writedata  = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    misalign_c = 1'b0;
    complete_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && is_mem_op(opcode)) begin
          if (addr_misaligned(req_size_c, eff_addr[1:0])) begin
            misalign_c = 1'b1;
          end else begin
            accept_c   = 1'b1;
            state_next = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (!mem_waitrequest) begin
          complete_c = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Attributes of the in-flight access, from the latched opcode
  always_comb begin
    held_size_c   = op_size(op_q);
    held_signed_c = is_signed_load(op_q);
    held_store_c  = is_store(op_q);
  end

  load_extend u_load_extend (
    .size      (held_size_c),
    .is_signed (held_signed_c),
    .addr_lo   (addr_lo_q),
    .readdata  (mem_readdata),
    .result_c  (ext_data_c)
  );

  // Registered bus and status outputs; bus fields stay put through wait states
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q           <= '0;
      addr_lo_q      <= '0;
      mem_address    <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      load_data      <= '0;
      misaligned     <= 1'b0;
    end else begin
      misaligned <= misalign_c;
      done       <= complete_c;
      if (accept_c) begin
        op_q           <= opcode;
        addr_lo_q      <= eff_addr[1:0];
        mem_address    <= req_c.address;
        mem_byteenable <= req_c.byteenable;
        mem_writedata  <= req_c.writedata;
        mem_read       <= ~is_store(opcode);
        mem_write      <= is_store(opcode);
        busy           <= 1'b1;
      end
      if (complete_c) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        if (!held_store_c) begin
          load_data <= ext_data_c;
        end
      end
      if (state == ST_DONE) begin
        busy <= 1'b0;
      end
    end
  end

endmodule
